pump_station_scheduler: RTL

//  Supervisory scheduler for the two-pump sump station. Debounces the I/S level sensors,

---
 rtl/pump_station_pkg.sv | 29 ++
 rtl/level_debouncer.sv | 59 +++++
 rtl/pump_station_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pump_station_pkg.sv
// Shared encodings for the two-pump sump station scheduler: FSM states, level codes, pump bits.
package pump_station_pkg;

  localparam int unsigned LVL_W  = 2;
  localparam int unsigned PUMP_W = 2;
  localparam int unsigned B1_BIT = 0;
  localparam int unsigned B2_BIT = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_LEAD = 2'd1,
    RUN_BOTH = 2'd2,
    SAFE     = 2'd3
  } state_e;

  // bit0 = I (low sensor), bit1 = S (high sensor)
  typedef enum logic [LVL_W-1:0] {
    LVL_LOW     = 2'b00,
    LVL_MID     = 2'b01,
    LVL_INVALID = 2'b10,
    LVL_HIGH    = 2'b11
  } level_e;

  // One-hot contactor mask for pump index 0 (B1) or 1 (B2)
  function automatic logic [PUMP_W-1:0] pump_mask(input logic pump_sel);
    pump_mask = PUMP_W'(1) << pump_sel;
  endfunction

endpackage

// File: rtl/level_debouncer.sv
// Two-flop synchronizer plus debounce filter for the 2-bit I/S level sensor bus.
module level_debouncer
  import pump_station_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [LVL_W-1:0] level_async,
  output level_e           level_filt
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [LVL_W-1:0] sync1_q, sync2_q;
  logic [LVL_W-1:0] cand_q, cand_d;
  logic [DB_W-1:0]  cnt_q, cnt_d;
  level_e           filt_q, filt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      filt_q  <= LVL_LOW;
    end else begin
      sync1_q <= level_async;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
    end
  end

  // Count consecutive identical samples that differ from the accepted level
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else begin
      if (sync2_q != cand_q) begin
        cand_d = sync2_q;
        cnt_d  = DB_W'(1);
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
      if (cnt_d >= DB_W'(DEBOUNCE_CYCLES)) begin
        filt_d = level_e'(sync2_q);
        cnt_d  = '0;
      end
    end
  end

  assign level_filt = filt_q;

endmodule

// File: rtl/pump_station_scheduler.sv
// Lead/lag scheduler for the two-pump sump station with min-run, solo handover and fault routing.
// Optional per-pump runtime counters are built when PUMP_RUNTIME_CNT_EN is defined.
module pump_station_scheduler
  import pump_station_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MIN_ON_CYCLES   = 16,
  parameter int unsigned MAX_SOLO_CYCLES = 1024,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [LVL_W-1:0]  level_sensors,
  input  logic [PUMP_W-1:0] pump_fault,
  output logic [PUMP_W-1:0] pumps,
  output logic              lead_pump,
  output logic              alarm,
  output logic              sensor_error
`ifdef PUMP_RUNTIME_CNT_EN
  ,
  output logic [CNT_W-1:0]  runtime_b1,
  output logic [CNT_W-1:0]  runtime_b2
`endif
);

  level_e            level;
  state_e            state_q, state_d;
  logic              lead_q, lead_d;
  logic [CNT_W-1:0]  min_q, min_d;
  logic [CNT_W-1:0]  solo_q, solo_d;
  logic [PUMP_W-1:0] pumps_q, pumps_d;
  logic              alarm_q, alarm_d;
  logic              serr_q, serr_d;
  logic              min_met;
  logic              eff_lead;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  level_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock       (clock),
    .reset       (reset),
    .level_async (level_sensors),
    .level_filt  (level)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lead_q  <= 1'b0;
      min_q   <= '0;
      solo_q  <= '0;
      pumps_q <= '0;
      alarm_q <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lead_q  <= lead_d;
      min_q   <= min_d;
      solo_q  <= solo_d;
      pumps_q <= pumps_d;
      alarm_q <= alarm_d;
      serr_q  <= serr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lead_d   = lead_q;
    min_d    = min_q;
    solo_d   = solo_q;
    min_met  = (min_q >= CNT_W'(MIN_ON_CYCLES));
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (level == LVL_MID || level == LVL_HIGH) begin
            state_d = (level == LVL_MID) ? RUN_LEAD : RUN_BOTH;
            min_d   = '0;
            solo_d  = '0;
          end else if (level == LVL_INVALID) begin
            state_d = SAFE;
          end
        end
        RUN_LEAD: begin
          min_d = sat_inc(min_q);
          if (level == LVL_INVALID) begin
            state_d = SAFE;
          end else if (level == LVL_HIGH) begin
            state_d = RUN_BOTH;
          end else if (level == LVL_LOW && min_met) begin
            state_d = IDLE;
            lead_d  = ~lead_q;
          end else begin
            // Still running solo: hand the duty over once the solo budget is used up
            solo_d = sat_inc(solo_q);
            if (solo_d >= CNT_W'(MAX_SOLO_CYCLES)) begin
              lead_d = ~lead_q;
              solo_d = '0;
            end
          end
        end
        RUN_BOTH: begin
          min_d = sat_inc(min_q);
          if (level == LVL_INVALID) begin
            state_d = SAFE;
          end else if (level == LVL_MID) begin
            state_d = RUN_LEAD;
            lead_d  = ~lead_q;
            solo_d  = '0;
          end else if (level == LVL_LOW && min_met) begin
            state_d = IDLE;
            lead_d  = ~lead_q;
          end
        end
        SAFE: begin
          if (level != LVL_INVALID) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs follow the next state so they appear on the same edge as the transition
    eff_lead = lead_d ^ pump_fault[lead_d];
    case (state_d)
      RUN_LEAD: pumps_d = pump_mask(eff_lead) & ~pump_fault;
      RUN_BOTH: pumps_d = ~pump_fault;
      default:  pumps_d = '0;
    endcase
    alarm_d = (&pump_fault) | ((state_d == RUN_BOTH) & (|pump_fault));
    serr_d  = (state_d == SAFE);
  end

  assign pumps        = pumps_q;
  assign lead_pump    = lead_q;
  assign alarm        = alarm_q;
  assign sensor_error = serr_q;

`ifdef PUMP_RUNTIME_CNT_EN
  logic [CNT_W-1:0] rt_b1_q, rt_b1_d;
  logic [CNT_W-1:0] rt_b2_q, rt_b2_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rt_b1_q <= '0;
      rt_b2_q <= '0;
    end else begin
      rt_b1_q <= rt_b1_d;
      rt_b2_q <= rt_b2_d;
    end
  end

  always_comb begin
    rt_b1_d = rt_b1_q;
    rt_b2_d = rt_b2_q;
    if (pumps_q[B1_BIT]) rt_b1_d = sat_inc(rt_b1_q);
    if (pumps_q[B2_BIT]) rt_b2_d = sat_inc(rt_b2_q);
  end

  assign runtime_b1 = rt_b1_q;
  assign runtime_b2 = rt_b2_q;
`endif

endmodule
